// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants, target state encoding and default codec address
package i2c_pkg;

    localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;
    localparam logic       I2C_ACK        = 1'b0;
    localparam logic       I2C_NACK       = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_BYTE0,
        ST_ACK0,
        ST_BYTE1,
        ST_ACK1,
        ST_WAIT_STOP,
        ST_RD_BYTE,
        ST_RD_ACK
    } tgt_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with START/STOP and SCL edge pulses
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall
);

    logic [STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [STAGES-1:0] sda_sync_q, sda_sync_d;
    logic              scl_prev_q, scl_prev_d;
    logic              sda_prev_q, sda_prev_d;
    logic              scl_s, sda_s;

    assign scl_s = scl_sync_q[STAGES-1];
    assign sda_s = sda_sync_q[STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Idle bus is high on both lines, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda      = sda_s;
    assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;

endmodule

// File: rtl/i2c_codec_target.sv
// rtl/i2c_codec_target.sv - I2C codec control-port target with shadow register file
// Optional register readback enabled by I2C_CODEC_TARGET_READBACK_EN.
module i2c_codec_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = CODEC_DEV_ADDR,
    parameter int         NR_REGS     = 64,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr,
    output logic [6:0] reg_waddr,
    output logic [8:0] reg_wdata,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);

    localparam int         AW        = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;
    localparam logic [7:0] NR_REGS_W = 8'(NR_REGS);
`ifdef I2C_CODEC_TARGET_READBACK_EN
    localparam logic RD_OK = 1'b1;
`else
    localparam logic RD_OK = 1'b0;
`endif

    logic sda_s, start, stop, scl_rise, scl_fall;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_line_sync (
        .clk      (clk),
        .reset_   (reset_),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda_s),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    tgt_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte0_q, byte0_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       reg_wr_q, reg_wr_d;
    logic [6:0] reg_waddr_q, reg_waddr_d;
    logic [8:0] reg_wdata_q, reg_wdata_d;
    logic [8:0] regs_q [NR_REGS];

    logic [7:0] shift_in;
    logic [6:0] frame_addr;
    logic       frame_ok;
    logic       addr_resp;

    assign shift_in   = {shift_q[6:0], sda_s};
    assign frame_addr = byte0_q[7:1];
    assign frame_ok   = {1'b0, frame_addr} < NR_REGS_W;
    assign addr_resp  = (shift_q[7:1] == DEV_ADDR && (!shift_q[0] || RD_OK)) ? I2C_ACK : I2C_NACK;

`ifdef I2C_CODEC_TARGET_READBACK_EN
    logic [6:0] ptr_q, ptr_d, ptr_next;
    logic [7:0] tx_q, tx_d;
    logic       byte_sel_q, byte_sel_d;

    assign ptr_next = ({1'b0, ptr_q} == NR_REGS_W - 8'd1) ? 7'd0 : ptr_q + 7'd1;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte0_d     = byte0_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_wr_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
`ifdef I2C_CODEC_TARGET_READBACK_EN
        ptr_d       = ptr_q;
        tx_d        = tx_q;
        byte_sel_d  = byte_sel_q;
`endif
        if (start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE0, ST_BYTE1: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Out-of-range register writes are still ACKed but leave no trace.
                        if (state_q == ST_BYTE1 && bit_cnt_q == 4'd7 && frame_ok) begin
                            reg_wr_d    = 1'b1;
                            reg_waddr_d = frame_addr;
                            reg_wdata_d = {byte0_q[0], shift_in};
`ifdef I2C_CODEC_TARGET_READBACK_EN
                            ptr_d       = frame_addr;
`endif
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_ADDR) begin
                            if (addr_resp == I2C_ACK) begin
                                state_d  = ST_ADDR_ACK;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else begin
                            state_d  = (state_q == ST_BYTE0) ? ST_ACK0 : ST_ACK1;
                            byte0_d  = (state_q == ST_BYTE0) ? shift_q : byte0_q;
                            sda_oe_d = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_ACK0, ST_ACK1: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = (state_q == ST_ACK0) ? ST_BYTE1 : ST_BYTE0;
`ifdef I2C_CODEC_TARGET_READBACK_EN
                        if (state_q == ST_ADDR_ACK && shift_q[0]) begin
                            state_d    = ST_RD_BYTE;
                            tx_d       = {ptr_q, regs_q[ptr_q[AW-1:0]][8]};
                            sda_oe_d   = ~ptr_q[6];
                            byte_sel_d = 1'b0;
                        end
`endif
                    end
                end
`ifdef I2C_CODEC_TARGET_READBACK_EN
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            state_d   = ST_RD_ACK;
                            bit_cnt_d = 4'd0;
                        end else begin
                            tx_d      = {tx_q[6:0], 1'b0};
                            sda_oe_d  = ~tx_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_s == I2C_NACK) begin
                        state_d = ST_WAIT_STOP;
                    end else if (scl_fall) begin
                        state_d = ST_RD_BYTE;
                        if (!byte_sel_q) begin
                            tx_d       = regs_q[ptr_q[AW-1:0]][7:0];
                            sda_oe_d   = ~regs_q[ptr_q[AW-1:0]][7];
                            byte_sel_d = 1'b1;
                        end else begin
                            ptr_d      = ptr_next;
                            tx_d       = {ptr_next, regs_q[ptr_next[AW-1:0]][8]};
                            sda_oe_d   = ~ptr_next[6];
                            byte_sel_d = 1'b0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            byte0_q     <= 8'd0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_waddr_q <= 7'd0;
            reg_wdata_q <= 9'd0;
`ifdef I2C_CODEC_TARGET_READBACK_EN
            ptr_q       <= 7'd0;
            tx_q        <= 8'd0;
            byte_sel_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte0_q     <= byte0_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_wr_q    <= reg_wr_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
`ifdef I2C_CODEC_TARGET_READBACK_EN
            ptr_q       <= ptr_d;
            tx_q        <= tx_d;
            byte_sel_q  <= byte_sel_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < NR_REGS; i++) regs_q[i] <= 9'd0;
        end else if (reg_wr_d) begin
            regs_q[reg_waddr_d[AW-1:0]] <= reg_wdata_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign reg_wr    = reg_wr_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign rd_data   = ({1'b0, rd_addr} < NR_REGS_W) ? regs_q[rd_addr[AW-1:0]] : 9'd0;

endmodule
